mem_io_buf: RTL
===============

Name: mem_io_buf

Overview:
- Sits between memctrl's RAM/IO byte bus and the external memory/UART bus.
- Queues byte writes to the I/O region (addr[17:16]==2'b11) in a FIFO and drains them only while io_buffer_full is low, so memctrl never has to watch the UART.
- RAM accesses and I/O reads pass straight through.
- I/O reads are held until every earlier queued I/O write has been issued, preserving program order.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- rdy  in  1  global ready; freezes the block when low
- up_req  in  1  memctrl drives a bus access this cycle
- up_wr  in  1  1 = write, 0 = read
- up_addr  in  32  byte address
- up_dout  in  8  write data
- up_din  out  8  read data returned to memctrl, = ram_din
- up_stall  out  1  access not accepted; memctrl holds up_req/up_wr/up_addr/up_dout stable
- ram_wr  out  1  external write strobe
- ram_a  out  32  external address
- ram_dout  out  8  external write data
- ram_din  in  8  external read data; valid the cycle after a read
- io_buffer_full  in  1  UART transmit buffer full
- buf_empty  out  1  FIFO holds no entries

Behaviour:
- FIFO entry = {addr[31:0], data[7:0]}. Pointers are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits, range 0..DEPTH.
- Request classes, decoded from the up_* inputs:
  - io = up_req & (up_addr[17:16]==2'b11)
  - IOW = io & up_wr
  - IOR = io & ~up_wr
  - MEM = up_req & ~io
- MEM request:
  - Bus is driven combinationally: ram_wr=up_wr, ram_a=up_addr, ram_dout=up_dout.
  - up_stall=0. No drain occurs this cycle.
- IOW request:
  - count<DEPTH: push at the clock edge, up_stall=0.
  - count==DEPTH: up_stall=1, no push. A pop in the same cycle does NOT make room; the push is retried next cycle.
- IOR request:
  - buf_empty=1: pass through exactly like MEM, up_stall=0.
  - Otherwise: up_stall=1 and the FSM enters FLUSH.
- Drain (pop):
  - Enabled in a cycle when count>0, io_buffer_full=0 and the bus is free.
  - The bus is free when up_req=0, or the request is IOW, or the request is IOR being stalled.
  - On a drain: ram_wr=1, ram_a=head.addr, ram_dout=head.data; pop at the edge.
  - At most one drain per cycle.
- Simultaneous IOW push and drain is legal when count<DEPTH. In that case count is unchanged.
- Idle bus: ram_wr=0, ram_a=0, ram_dout=0.
- FSM states:
  - IDLE:
    - IOR with a non-empty FIFO -> FLUSH.
    - Otherwise stay in IDLE.
  - FLUSH:
    - up_stall=1 whenever up_req=1.
    - Drains follow the normal rule.
    - When count reaches 0, go to IDLE on the next edge; the held IOR then passes through.
  - GAP: only exists with IO_GAP_EN (see Optional Feature).
- rdy=0:
  - No pointer, count or state change.
  - ram_wr forced 0. up_stall forced 1 if up_req=1.
- Reset (rst==0 at a clock edge):
  - Pointers=0, count=0, state=IDLE, buf_empty=1, ram_wr=0, ram_a=0, ram_dout=0, up_stall=0.
  - While rst is low, all bus outputs are held at 0.
  - Reset mid-drain discards every queued byte.
- No rollback input. Stores reach memctrl only at ROB commit, so queued writes are never speculative.
- buf_empty is (count==0), registered state.

Optional Feature:
- Macro IO_GAP_EN.
- When defined: after each drain the FSM enters GAP for one cycle.
  - No drain occurs in GAP.
  - MEM, IOW and IOR handling is unchanged in GAP.
  - GAP then returns to IDLE, or to FLUSH if a flush is pending.
  - Purpose: covers the one-cycle latency of io_buffer_full.
- When undefined: back-to-back drains are allowed and the GAP state does not exist.

Decomposition:
- Shared header (utils.v style) holds:
  - IO region test macro (addr[17:16]==2'b11)
  - FSM state encodings: IDLE=2'd0, FLUSH=2'd1, GAP=2'd2
  - entry width 40
- Natural sub-module: io_fifo, a generic synchronous FIFO with push/pop/full/empty/count, parameterised by DEPTH and width 40.
- mem_io_buf holds the FSM and the bus mux.

Test Plan:
- Write 0x41 to 0x30000 with io_buffer_full=0 and up_req low afterwards -> push at edge 1; edge 2 cycle shows ram_wr=1, ram_a=0x30000, ram_dout=0x41; buf_empty=1 afterwards.
- io_buffer_full=1, nine IOWs 0x01..0x09 with DEPTH=8 -> first eight accepted; ninth has up_stall=1 and is held. Release full -> bytes drain in order 0x01..0x08; the ninth is accepted after the first pop.
- Three queued IOWs, then IOR of 0x30004 -> up_stall=1 until the third drain; read is issued with ram_wr=0, ram_a=0x30004 the cycle after buf_empty=1.
- IOW queued while memctrl streams MEM reads at 0x1000..0x1003 -> MEM reads pass through unstalled; the IO byte drains only in the first cycle with up_req=0.
- rdy=0 for 3 cycles with 2 entries queued and io_buffer_full=0 -> no ram_wr and count stays 2; drains resume when rdy=1.
- IO_GAP_EN defined, 4 queued bytes, bus idle -> ram_wr pattern 1,0,1,0,1,0,1. Without the macro -> 1,1,1,1.

Source files
------------

// File: rtl/mem_io_buf_pkg.sv
// Shared definitions for the memctrl-side I/O write buffer.
// IO_GAP_EN adds the GAP state that spaces successive UART drains by one cycle.
package mem_io_buf_pkg;

  // One queued I/O write: {addr[31:0], data[7:0]}.
  localparam int unsigned ENTRY_W = 40;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1
`ifdef IO_GAP_EN
    , ST_GAP = 2'd2
`endif
  } state_e;

  // The I/O region occupies addr[17:16] == 2'b11.
  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_io_buf_fifo.sv
// Generic synchronous FIFO with registered count and empty flag.
// Pushes into a full FIFO and pops from an empty one are ignored.
module io_fifo
  import mem_io_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Qualify push/pop against occupancy and compute next pointers and count.
  always_comb begin
    do_push  = push & (count_q != FULL_CNT);
    do_pop   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    empty_d  = (count_d == '0);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  // Pointer, count and empty-flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == FULL_CNT);
  assign empty = empty_q;

endmodule

// File: rtl/mem_io_buf.sv
// Byte-bus buffer between memctrl and the external memory/UART bus.
// I/O-region writes are queued and drained while the UART has room; RAM
// accesses and I/O reads pass through, with I/O reads held until all older
// queued writes are out. Define IO_GAP_EN to insert one idle cycle after
// every drain.
module mem_io_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        up_req,
  input  logic        up_wr,
  input  logic [31:0] up_addr,
  input  logic [7:0]  up_dout,
  output logic [7:0]  up_din,
  output logic        up_stall,
  output logic        ram_wr,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  input  logic        io_buffer_full,
  output logic        buf_empty
);

  import mem_io_buf_pkg::*;

  state_e             state_q, state_d;
  entry_t             head, push_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic [PTR_W:0]     count;
  logic               fifo_full, fifo_empty;
  logic               io, iow, ior, in_gap;
  logic               stall, bus_free, drain, push, pass;

  io_fifo #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (drain),
    .din  (push_entry),
    .head (head_bits),
    .count(count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head       = entry_t'(head_bits);
  assign push_entry = '{addr: up_addr, data: up_dout};
  assign buf_empty  = fifo_empty;
  assign up_din     = ram_din;

`ifdef IO_GAP_EN
  assign in_gap = (state_q == ST_GAP);
`else
  assign in_gap = 1'b0;
`endif

  // Classify the incoming request.
  always_comb begin
    io  = up_req & is_io_addr(up_addr);
    iow = io & up_wr;
    ior = io & ~up_wr;
  end

  // Acceptance, push and drain decisions. A stalled I/O read leaves the bus
  // free so the queue ahead of it can drain; a pop never frees room for a
  // push in the same cycle because stall is decided from the current count.
  always_comb begin
    stall = 1'b0;
    if (!rdy || state_q == ST_FLUSH) stall = up_req;
    else if (iow)                    stall = fifo_full;
    else if (ior)                    stall = ~fifo_empty;
    bus_free = ~up_req | iow | (ior & stall);
    drain    = rdy & (count != '0) & ~io_buffer_full & bus_free & ~in_gap;
    push     = rdy & iow & ~stall;
    pass     = rdy & up_req & ~stall & ~iow;
  end

  // Next-state logic for the flush controller.
  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
`ifdef IO_GAP_EN
          if (drain)                     state_d = ST_GAP;
          else
`endif
          if (ior && !fifo_empty)        state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
`ifdef IO_GAP_EN
          if (drain)                     state_d = ST_GAP;
          else
`endif
          if (fifo_empty)                state_d = ST_IDLE;
        end
`ifdef IO_GAP_EN
        ST_GAP: begin
          state_d = (ior && !fifo_empty) ? ST_FLUSH : ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flush controller state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // External bus mux: a drain owns the bus, else a passing request, else idle.
  always_comb begin
    ram_wr   = 1'b0;
    ram_a    = '0;
    ram_dout = '0;
    up_stall = 1'b0;
    if (rst) begin
      up_stall = stall;
      if (drain) begin
        ram_wr   = 1'b1;
        ram_a    = head.addr;
        ram_dout = head.data;
      end else if (pass) begin
        ram_wr   = up_wr;
        ram_a    = up_addr;
        ram_dout = up_dout;
      end
    end
  end

endmodule
